// File: rtl/sensor_error_monitor.sv
// Debounces the registered sensor error flag into a latched, acknowledgeable alarm
// and keeps a saturating count of confirmed fault episodes.
module sensor_error_monitor #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 error_in,
    input  logic                 ack,
    input  logic                 clr_count,
    output logic                 alarm,
    output logic [CNT_WIDTH-1:0] fault_count,
    output logic                 count_sat
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_ALARM   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [7:0]           RUN_LAST = 8'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    state_t                 state_q, state_d;
    logic                   error_s_q;
    logic [7:0]             run_cnt_q, run_cnt_d;
    logic                   alarm_q, alarm_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   enter_alarm_s;

    // Episode FSM: qualifies runs of error_s and tracks the alarm/ack handshake.
    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        enter_alarm_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                run_cnt_d = 8'd0;
                if (error_s_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d       = ST_ALARM;
                        enter_alarm_s = 1'b1;
                    end else begin
                        state_d   = ST_QUALIFY;
                        run_cnt_d = 8'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUALIFY: begin
                if (!error_s_q) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = 8'd0;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d       = ST_ALARM;
                    run_cnt_d     = 8'd0;
                    enter_alarm_s = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 8'd1;
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    state_d = error_s_q ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            ST_HOLD: begin
                if (!error_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                run_cnt_d = 8'd0;
            end
        endcase
        alarm_d = (state_d == ST_ALARM);
    end

    // Episode counter; a clear on the same edge as an alarm entry still counts that entry.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_count) begin
            count_d = enter_alarm_s ? CNT_ONE : {CNT_WIDTH{1'b0}};
            sat_d   = 1'b0;
        end else if (enter_alarm_s) begin
            if (count_q == CNT_MAX) begin
                count_d = count_q;
                sat_d   = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
                sat_d   = sat_q | ((count_q + CNT_ONE) == CNT_MAX);
            end
        end else begin
            count_d = count_q;
            sat_d   = sat_q;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            error_s_q <= 1'b0;
            run_cnt_q <= 8'd0;
            alarm_q   <= 1'b0;
            count_q   <= {CNT_WIDTH{1'b0}};
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            error_s_q <= error_in;
            run_cnt_q <= run_cnt_d;
            alarm_q   <= alarm_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign alarm       = alarm_q;
    assign fault_count = count_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_sensor_error_monitor.sv
// Drives three parameterisations of sensor_error_monitor with shared stimulus and
// compares each against an episode-level reference model.
module tb_sensor_error_monitor;

    logic clk = 1'b0;
    logic rst, error_in, ack, clr_count;
    logic       alarm0, alarm1, alarm2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic       sat0, sat1, sat2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sensor_error_monitor #(.DEBOUNCE(4), .CNT_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .error_in(error_in), .ack(ack), .clr_count(clr_count),
        .alarm(alarm0), .fault_count(cnt0), .count_sat(sat0));
    sensor_error_monitor #(.DEBOUNCE(4), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .error_in(error_in), .ack(ack), .clr_count(clr_count),
        .alarm(alarm1), .fault_count(cnt1), .count_sat(sat1));
    sensor_error_monitor #(.DEBOUNCE(1), .CNT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .error_in(error_in), .ack(ack), .clr_count(clr_count),
        .alarm(alarm2), .fault_count(cnt2), .count_sat(sat2));

    // Reference model: per instance, length of the current high streak, whether an
    // episode has already been confirmed, alarm level and episode count.
    int D_p[3]    = '{4, 4, 1};
    int MAX_p[3]  = '{255, 3, 255};
    int streak[3];
    bit episode[3];
    bit m_alarm[3];
    int m_cnt[3];
    bit m_sat[3];
    bit es;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit entry;
        for (int i = 0; i < 3; i++) begin
            entry = 1'b0;
            if (rst) begin
                streak[i] = 0; episode[i] = 1'b0; m_alarm[i] = 1'b0;
                m_cnt[i] = 0; m_sat[i] = 1'b0;
            end else begin
                if (!episode[i]) begin
                    streak[i] = es ? streak[i] + 1 : 0;
                    if (streak[i] >= D_p[i]) begin
                        episode[i] = 1'b1; m_alarm[i] = 1'b1; entry = 1'b1;
                    end
                end else if (m_alarm[i]) begin
                    if (ack) begin
                        m_alarm[i] = 1'b0;
                        if (!es) begin episode[i] = 1'b0; streak[i] = 0; end
                    end
                end else if (!es) begin
                    episode[i] = 1'b0; streak[i] = 0;
                end
                if (clr_count) begin
                    m_cnt[i] = entry ? 1 : 0;
                    m_sat[i] = 1'b0;
                end else if (entry) begin
                    if (m_cnt[i] < MAX_p[i]) m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == MAX_p[i]) m_sat[i] = 1'b1;
                end
            end
        end
        es = rst ? 1'b0 : error_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("alarm0", 32'(alarm0), 32'(m_alarm[0]));
        check("count0", 32'(cnt0),   32'(m_cnt[0]));
        check("sat0",   32'(sat0),   32'(m_sat[0]));
        check("alarm1", 32'(alarm1), 32'(m_alarm[1]));
        check("count1", 32'(cnt1),   32'(m_cnt[1]));
        check("sat1",   32'(sat1),   32'(m_sat[1]));
        check("alarm2", 32'(alarm2), 32'(m_alarm[2]));
        check("count2", 32'(cnt2),   32'(m_cnt[2]));
        check("sat2",   32'(sat2),   32'(m_sat[2]));
    endtask

    task automatic drive(input bit e, input bit a, input bit c, input bit r, input int n);
        error_in = e; ack = a; clr_count = c; rst = r;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        es = 1'b0;
        for (int i = 0; i < 3; i++) begin
            streak[i] = 0; episode[i] = 1'b0; m_alarm[i] = 1'b0; m_cnt[i] = 0; m_sat[i] = 1'b0;
        end
        error_in = 1'b0; ack = 1'b0; clr_count = 1'b0; rst = 1'b1;
        #2;
        drive(0, 0, 0, 1, 2);
        check("reset_alarm", 32'(alarm0), 32'd0);
        check("reset_count", 32'(cnt0),   32'd0);
        check("reset_sat",   32'(sat0),   32'd0);

        // glitch of 3 samples is rejected with DEBOUNCE=4
        drive(1, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 5);
        check("glitch_alarm", 32'(alarm0), 32'd0);
        check("glitch_count", 32'(cnt0),   32'd0);

        // held error: alarm exactly 4 edges after the first sampling edge
        drive(1, 0, 0, 0, 4);
        check("lat_before", 32'(alarm0), 32'd0);
        drive(1, 0, 0, 0, 1);
        check("lat_at", 32'(alarm0), 32'd1);
        check("first_count", 32'(cnt0), 32'd1);
        drive(1, 0, 0, 0, 3);

        // ack while still erroring, hold, then a fresh episode
        drive(1, 1, 0, 0, 1);
        check("ack_clears", 32'(alarm0), 32'd0);
        drive(1, 0, 0, 0, 10);
        check("hold_no_realarm", 32'(alarm0), 32'd0);
        drive(0, 0, 0, 0, 2);
        drive(1, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 3);
        check("second_alarm", 32'(alarm0), 32'd1);
        check("second_count", 32'(cnt0),   32'd2);

        // three more episodes to saturate the 2-bit counter
        for (int ep = 0; ep < 3; ep++) begin
            drive(0, 1, 0, 0, 3);
            drive(1, 0, 0, 0, 4);
            drive(0, 0, 0, 0, 3);
        end
        check("sat_count", 32'(cnt1), 32'd3);
        check("sat_flag",  32'(sat1), 32'd1);

        // clear coinciding with the sixth alarm entry
        drive(0, 1, 0, 0, 3);
        drive(1, 0, 0, 0, 4);
        drive(0, 0, 1, 0, 1);
        check("clr_entry_count", 32'(cnt1), 32'd1);
        check("clr_entry_sat",   32'(sat1), 32'd0);
        check("clr_entry_alarm", 32'(alarm1), 32'd1);

        // reset while in ALARM discards the episode
        drive(0, 0, 0, 0, 2);
        drive(1, 1, 0, 0, 2);
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 3);
        drive(1, 0, 0, 0, 6);
        drive(1, 0, 0, 1, 1);
        check("rst_mid_alarm", 32'(alarm0), 32'd0);
        check("rst_mid_count", 32'(cnt0),   32'd0);
        drive(1, 0, 0, 0, 4);
        check("rst_rearm_early", 32'(alarm0), 32'd0);
        drive(1, 0, 0, 0, 1);
        check("rst_rearm", 32'(alarm0), 32'd1);
        check("rst_rearm_count", 32'(cnt0), 32'd1);

        // DEBOUNCE=1: single-cycle pulse alarms, ack with error low returns to IDLE
        drive(0, 1, 0, 0, 3);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        check("d1_alarm", 32'(alarm2), 32'd1);
        drive(0, 1, 0, 0, 1);
        check("d1_ack", 32'(alarm2), 32'd0);
        drive(0, 0, 0, 0, 2);

        // randomized bursts
        for (int blk = 0; blk < 600; blk++) begin
            int len;
            bit e;
            e   = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                drive(e, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                      ($urandom_range(0, 199) == 0), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
